// File: rtl/aes_block_dma_sequencer.sv
// AES block DMA sequencer: streams N 128-bit blocks from the bridge window
// through the AES core and back to the bridge, one block in flight at a time.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for cmd_start
// RD_REQ   | bridge read of the current source word outstanding
// AES_SEND | plaintext offered to the AES core
// AES_WAIT | waiting for ciphertext from the AES core
// WR_REQ   | bridge write of the result outstanding
// DONE     | completion; done pulses on the following cycle
module aes_block_dma_sequencer #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_start,
   input  logic [ADDR_W-1:0]     cmd_src_addr,
   input  logic [ADDR_W-1:0]     cmd_dst_addr,
   input  logic [ADDR_W:0]       cmd_num_blocks,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_W:0]       blocks_done,
   output logic                  aes_in_valid,
   output logic [DATA_W-1:0]     aes_in_data,
   input  logic                  aes_in_ready,
   input  logic                  aes_out_valid,
   input  logic [DATA_W-1:0]     aes_out_data,
   output logic                  aes_out_ready,
   output logic [ADDR_W-1:0]     bus_address,
   output logic [DATA_W/8-1:0]   bus_byte_enable,
   output logic                  bus_read,
   output logic                  bus_write,
   output logic [DATA_W-1:0]     bus_write_data,
   input  logic                  bus_acknowledge,
   input  logic [DATA_W-1:0]     bus_read_data
);

   localparam int BE_W   = DATA_W / 8;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_REQ   = 3'd1;
   localparam logic [2:0] AES_SEND = 3'd2;
   localparam logic [2:0] AES_WAIT = 3'd3;
   localparam logic [2:0] WR_REQ   = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   localparam logic [ADDR_W:0]   ONE_CNT   = 1;
   localparam logic [ADDR_W-1:0] ONE_ADDR  = 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W:0]   blocks_done_q, blocks_done_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              aes_in_valid_q, aes_in_valid_d;
   logic [DATA_W-1:0] aes_in_data_q, aes_in_data_d;
   logic              aes_out_ready_q, aes_out_ready_d;
   logic [ADDR_W-1:0] bus_address_q, bus_address_d;
   logic [BE_W-1:0]   bus_byte_enable_q, bus_byte_enable_d;
   logic              bus_read_q, bus_read_d;
   logic              bus_write_q, bus_write_d;
   logic [DATA_W-1:0] bus_write_data_q, bus_write_data_d;
   logic              req_expired;

   // wait_q counts down from TIMEOUT; the request is abandoned on the cycle
   // it would otherwise pass 1, so the request is visible for TIMEOUT cycles
   always_comb begin
      state_d          = state_q;
      src_d            = src_q;
      dst_d            = dst_q;
      rem_d            = rem_q;
      blocks_done_d    = blocks_done_q;
      wait_d           = wait_q;
      busy_d           = busy_q;
      error_d          = error_q;
      aes_in_data_d    = aes_in_data_q;
      bus_write_data_d = bus_write_data_q;
      req_expired      = (TIMEOUT != 0) && (wait_q == WAIT_ONE);

      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               src_d         = cmd_src_addr;
               dst_d         = cmd_dst_addr;
               rem_d         = cmd_num_blocks;
               blocks_done_d = '0;
               error_d       = 1'b0;
               busy_d        = 1'b1;
               wait_d        = WAIT_INIT;
               state_d       = (cmd_num_blocks == '0) ? DONE : RD_REQ;
            end
         end
         RD_REQ: begin
            if (bus_acknowledge) begin
               aes_in_data_d = bus_read_data;
               state_d       = AES_SEND;
            end else if (req_expired) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q - WAIT_ONE;
            end
         end
         AES_SEND: begin
            if (aes_in_ready) begin
               state_d = AES_WAIT;
            end
         end
         AES_WAIT: begin
            if (aes_out_valid) begin
               bus_write_data_d = aes_out_data;
               wait_d           = WAIT_INIT;
               state_d          = WR_REQ;
            end
         end
         WR_REQ: begin
            if (bus_acknowledge) begin
               blocks_done_d = blocks_done_q + ONE_CNT;
               src_d         = src_q + ONE_ADDR;
               dst_d         = dst_q + ONE_ADDR;
               rem_d         = rem_q - ONE_CNT;
               wait_d        = WAIT_INIT;
               state_d       = (rem_q == ONE_CNT) ? DONE : RD_REQ;
            end else if (req_expired) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q - WAIT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // bus and AES strobes are registered copies of the next state
      done_d            = (state_q == DONE);
      bus_read_d        = (state_d == RD_REQ);
      bus_write_d       = (state_d == WR_REQ);
      aes_in_valid_d    = (state_d == AES_SEND);
      aes_out_ready_d   = (state_d == AES_WAIT);
      bus_byte_enable_d = (bus_read_d || bus_write_d) ? '1 : '0;
      if (bus_read_d) begin
         bus_address_d = src_d;
      end else if (bus_write_d) begin
         bus_address_d = dst_d;
      end else begin
         bus_address_d = bus_address_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         src_q             <= '0;
         dst_q             <= '0;
         rem_q             <= '0;
         blocks_done_q     <= '0;
         wait_q            <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         error_q           <= 1'b0;
         aes_in_valid_q    <= 1'b0;
         aes_in_data_q     <= '0;
         aes_out_ready_q   <= 1'b0;
         bus_address_q     <= '0;
         bus_byte_enable_q <= '0;
         bus_read_q        <= 1'b0;
         bus_write_q       <= 1'b0;
         bus_write_data_q  <= '0;
      end else begin
         state_q           <= state_d;
         src_q             <= src_d;
         dst_q             <= dst_d;
         rem_q             <= rem_d;
         blocks_done_q     <= blocks_done_d;
         wait_q            <= wait_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         error_q           <= error_d;
         aes_in_valid_q    <= aes_in_valid_d;
         aes_in_data_q     <= aes_in_data_d;
         aes_out_ready_q   <= aes_out_ready_d;
         bus_address_q     <= bus_address_d;
         bus_byte_enable_q <= bus_byte_enable_d;
         bus_read_q        <= bus_read_d;
         bus_write_q       <= bus_write_d;
         bus_write_data_q  <= bus_write_data_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign blocks_done     = blocks_done_q;
   assign aes_in_valid    = aes_in_valid_q;
   assign aes_in_data     = aes_in_data_q;
   assign aes_out_ready   = aes_out_ready_q;
   assign bus_address     = bus_address_q;
   assign bus_byte_enable = bus_byte_enable_q;
   assign bus_read        = bus_read_q;
   assign bus_write       = bus_write_q;
   assign bus_write_data  = bus_write_data_q;

endmodule

// File: tb/tb_aes_block_dma_sequencer.sv
// Bench for aes_block_dma_sequencer: a bridge responder with a fixed word
// pattern, an inverting AES model, and a table of directed commands.
module tb_aes_block_dma_sequencer;
   localparam int TMO = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cmd_start = 1'b0;
   logic [5:0]   cmd_src_addr = '0;
   logic [5:0]   cmd_dst_addr = '0;
   logic [6:0]   cmd_num_blocks = '0;
   logic         busy, done, error;
   logic [6:0]   blocks_done;
   logic         aes_in_valid;
   logic [127:0] aes_in_data;
   logic         aes_in_ready = 1'b0;
   logic         aes_out_valid = 1'b0;
   logic [127:0] aes_out_data = '0;
   logic         aes_out_ready;
   logic [5:0]   bus_address;
   logic [15:0]  bus_byte_enable;
   logic         bus_read, bus_write;
   logic [127:0] bus_write_data;
   logic         bus_acknowledge = 1'b0;
   logic [127:0] bus_read_data = '0;

   aes_block_dma_sequencer #(.ADDR_W(6), .DATA_W(128), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .cmd_start(cmd_start), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
      .cmd_num_blocks(cmd_num_blocks),
      .busy(busy), .done(done), .error(error), .blocks_done(blocks_done),
      .aes_in_valid(aes_in_valid), .aes_in_data(aes_in_data), .aes_in_ready(aes_in_ready),
      .aes_out_valid(aes_out_valid), .aes_out_data(aes_out_data), .aes_out_ready(aes_out_ready),
      .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
      .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
      .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] pat(input logic [5:0] a);
      logic [31:0] w;
      w = {a, 26'h2F0A5C3} ^ {26'd0, a};
      return {w, ~w, w ^ 32'h5A5A5A5A, w[15:0], w[31:16]};
   endfunction

   // test configuration, written only by the main process
   int bus_lat = 0;
   int aes_lat = 0;
   int withhold_abs = -1;
   bit bp = 1'b0;

   // bridge responder and event log
   int           rd_req_n = 0;
   int           held_len = 0;
   int           req_cycles = 0;
   int           ev_n = 0;
   int           bcnt = 0;
   bit           prev_rd = 1'b0;
   bit           pend_req = 1'b0;
   logic [5:0]   pend_addr = '0;
   logic         ev_kind [512];
   logic [5:0]   ev_addr [512];
   logic [127:0] ev_data [512];

   initial forever begin
      @(negedge clk);
      bus_acknowledge = 1'b0;
      bus_read_data   = {4{32'hBAD00BAD}};
      if (bus_read && !prev_rd) rd_req_n++;
      prev_rd = bus_read;
      if (bus_read || bus_write) begin
         req_cycles++;
         chk("rd_wr_exclusive", {159'd0, bus_read & bus_write}, 160'd0);
         if (pend_req) chk("bus_addr_stable", {154'd0, bus_address}, {154'd0, pend_addr});
         pend_req  = 1'b1;
         pend_addr = bus_address;
         if (bus_read && rd_req_n == withhold_abs) begin
            held_len++;
            bcnt = 0;
         end else if (bcnt >= bus_lat) begin
            bus_acknowledge = 1'b1;
            bcnt = 0;
            pend_req = 1'b0;
            chk("byte_enable", {144'd0, bus_byte_enable}, {144'd0, 16'hFFFF});
            if (ev_n < 512) begin
               ev_kind[ev_n] = bus_write;
               ev_addr[ev_n] = bus_address;
               ev_data[ev_n] = bus_write ? bus_write_data : 128'd0;
               ev_n++;
            end
            if (bus_read) bus_read_data = pat(bus_address);
         end else begin
            bcnt++;
         end
      end else begin
         bcnt = 0;
         pend_req = 1'b0;
      end
   end

   // AES model: ciphertext is the inverted plaintext after aes_lat cycles
   bit           aes_pend = 1'b0;
   int           aes_cnt = 0;
   logic [127:0] aes_res = '0;
   bit           in_hold = 1'b0;
   logic [127:0] in_hold_data = '0;

   initial forever begin
      @(negedge clk);
      if (in_hold && aes_in_valid) chk("aes_in_stable", {32'd0, aes_in_data}, {32'd0, in_hold_data});
      aes_in_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (aes_in_valid && aes_in_ready) begin
         aes_pend = 1'b1;
         aes_cnt  = aes_lat;
         aes_res  = ~aes_in_data;
         in_hold  = 1'b0;
      end else begin
         in_hold      = aes_in_valid;
         in_hold_data = aes_in_data;
      end
      aes_out_valid = 1'b0;
      aes_out_data  = {4{32'h0BADF00D}};
      if (aes_pend) begin
         if (aes_cnt > 0) begin
            aes_cnt--;
         end else if (!bp || $urandom_range(0, 1) == 1) begin
            aes_out_valid = 1'b1;
            aes_out_data  = aes_res;
            if (aes_out_ready) aes_pend = 1'b0;
         end
      end
   end

   typedef struct {
      logic [5:0] src;
      logic [5:0] dst;
      logic [6:0] cnt;
      int         bus_lat;
      int         aes_lat;
      int         withhold;
      bit         bp;
      int         exp_blocks;
      bit         exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input vec_t v, input string tag);
      int ev_base, req_base, held_base, start_cyc, done_cyc, ndone, i;
      logic [5:0] ra, wa;
      ev_base   = ev_n;
      req_base  = req_cycles;
      held_base = held_len;
      bus_lat   = v.bus_lat;
      aes_lat   = v.aes_lat;
      bp        = v.bp;
      withhold_abs = (v.withhold > 0) ? rd_req_n + v.withhold : -1;
      @(negedge clk);
      cmd_src_addr   = v.src;
      cmd_dst_addr   = v.dst;
      cmd_num_blocks = v.cnt;
      cmd_start      = 1'b1;
      start_cyc      = cyc;
      @(negedge clk);
      cmd_start = 1'b0;
      chk($sformatf("%s busy_after_start", tag), {159'd0, busy}, 160'd1);
      chk($sformatf("%s error_cleared", tag), {159'd0, error}, 160'd0);
      i = 0;
      while (!done && i < 1500) begin
         cmd_start = (v.bp && i == 12);
         if (cmd_start) begin
            cmd_src_addr   = 6'd50;
            cmd_dst_addr   = 6'd51;
            cmd_num_blocks = 7'd9;
         end
         @(negedge clk);
         i++;
      end
      cmd_start = 1'b0;
      chk($sformatf("%s done_seen", tag), {159'd0, done}, 160'd1);
      done_cyc = cyc;
      ndone = int'(done);
      @(negedge clk);
      chk($sformatf("%s busy_after_done", tag), {159'd0, busy}, 160'd0);
      ndone += int'(done);
      repeat (3) begin
         @(negedge clk);
         ndone += int'(done);
      end
      chk($sformatf("%s done_pulses", tag), 160'(ndone), 160'd1);
      chk($sformatf("%s blocks_done", tag), {153'd0, blocks_done}, 160'(v.exp_blocks));
      chk($sformatf("%s error", tag), {159'd0, error}, {159'd0, v.exp_err});
      if (v.cnt == 0) begin
         chk($sformatf("%s done_latency", tag), 160'(done_cyc - start_cyc), 160'd2);
         chk($sformatf("%s no_bus_req", tag), 160'(req_cycles - req_base), 160'd0);
      end
      if (v.withhold > 0)
         chk($sformatf("%s read_held_cycles", tag), 160'(held_len - held_base), 160'(TMO));
      chk($sformatf("%s bus_events", tag), 160'(ev_n - ev_base), 160'(2 * v.exp_blocks));
      for (int k = 0; k < v.exp_blocks; k++) begin
         ra = v.src + 6'(k);
         wa = v.dst + 6'(k);
         if (ev_base + 2 * k + 1 < ev_n) begin
            chk($sformatf("%s read%0d", tag, k),
                {153'd0, ev_kind[ev_base + 2 * k], ev_addr[ev_base + 2 * k]},
                {153'd0, 1'b0, ra});
            chk($sformatf("%s write%0d", tag, k),
                {25'd0, ev_kind[ev_base + 2 * k + 1], ev_addr[ev_base + 2 * k + 1],
                 ev_data[ev_base + 2 * k + 1]},
                {25'd0, 1'b1, wa, ~pat(ra)});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i, ndone;
      vecs[0] = '{6'd5,  6'd20, 7'd1,  2, 10, 0, 1'b0, 1,  1'b0};
      vecs[1] = '{6'd62, 6'd0,  7'd4,  0, 0,  0, 1'b0, 4,  1'b0};
      vecs[2] = '{6'd9,  6'd9,  7'd0,  0, 0,  0, 1'b0, 0,  1'b0};
      vecs[3] = '{6'd10, 6'd30, 7'd3,  1, 1,  2, 1'b0, 1,  1'b1};
      vecs[4] = '{6'd7,  6'd40, 7'd2,  0, 0,  0, 1'b0, 2,  1'b0};
      vecs[5] = '{6'd33, 6'd63, 7'd5,  1, 3,  0, 1'b1, 5,  1'b0};
      vecs[6] = '{6'd0,  6'd0,  7'd64, 0, 0,  0, 1'b0, 64, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_ctrl_outputs",
          {128'd0, busy, done, error, blocks_done, aes_in_valid, aes_out_ready, bus_read, bus_write, bus_byte_enable},
          160'd0);
      chk("reset_bus_address", {154'd0, bus_address}, 160'd0);
      chk("reset_write_data", {32'd0, bus_write_data}, 160'd0);
      chk("reset_aes_in_data", {32'd0, aes_in_data}, 160'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("v%0d", n));

      // reset while a write is outstanding
      bus_lat = 3;
      aes_lat = 2;
      bp = 1'b0;
      withhold_abs = -1;
      @(negedge clk);
      cmd_src_addr   = 6'd3;
      cmd_dst_addr   = 6'd9;
      cmd_num_blocks = 7'd2;
      cmd_start      = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      i = 0;
      while (!bus_write && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("rstmid write_reached", {159'd0, bus_write}, 160'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstmid bus_write_drop", {159'd0, bus_write}, 160'd0);
      chk("rstmid busy_drop", {159'd0, busy}, 160'd0);
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         ndone += int'(done);
      end
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         ndone += int'(done);
      end
      chk("rstmid no_done", 160'(ndone), 160'd0);
      chk("rstmid blocks_cleared", {153'd0, blocks_done}, 160'd0);
      run_vec(vecs[0], "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
